vga_sprite_gen: RTL and testbench

Pixel source that sits directly upstream of the VGA timing driver. It takes the driver's requested pixel coordinates and frame sync, and returns 12-bit RGB444 colour one clock later. That colour is a bouncing square sprite drawn over a grid background. The sprite position advances once per frame and only changes during vertical sync, so the image never tears.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_sprite_gen_if.sv | 23 ++
 rtl/vga_bounce_axis.sv | 59 +++++
 rtl/vga_sprite_gen.sv | 106 ++++++++++
 tb/tb_vga_sprite_gen.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and colour type for the timing driver and its pixel sources.
package vga_pkg;

  localparam logic [9:0] H_DISP = 10'd640;
  localparam logic [9:0] V_DISP = 10'd480;
  localparam int unsigned RGB_W = 12;

  typedef logic [RGB_W-1:0] rgb444_t;

  // Rotate colour by one nibble toward the MSBs, e.g. F00 -> 00F -> 0F0.
  function automatic rgb444_t rot_nibble(input rgb444_t c);
    return {c[7:0], c[11:8]};
  endfunction

endpackage

// File: rtl/vga_sprite_gen_if.sv
// Pixel request / response bundle between the VGA timing driver and a pixel source.
interface vga_sprite_gen_if;
  import vga_pkg::*;

  logic       vga_vs;
  logic [9:0] pixel_xpos;
  logic [9:0] pixel_ypos;
  logic       pause;
  rgb444_t    pixel_data;
  logic       bounce;
  logic [15:0] frame_cnt;

  modport master (
    output vga_vs, pixel_xpos, pixel_ypos, pause,
    input  pixel_data, bounce, frame_cnt
  );

  modport slave (
    input  vga_vs, pixel_xpos, pixel_ypos, pause,
    output pixel_data, bounce, frame_cnt
  );

endinterface

// File: rtl/vga_bounce_axis.sv
// One sprite axis: origin position and direction, reflecting at 0 and DISP - SIZE.
module vga_bounce_axis #(
  parameter logic [9:0] DISP  = 10'd640,
  parameter logic [9:0] SIZE  = 10'd32,
  parameter logic [9:0] SPEED = 10'd2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  output logic [9:0] o_pos,
  output logic       o_flip
);

  localparam logic [10:0] LIM  = {1'b0, DISP} - {1'b0, SIZE};
  localparam logic [10:0] STEP = {1'b0, SPEED};

  logic [9:0]  r_pos;
  logic        r_dir;  // 1: forward (right/down)
  logic [10:0] w_fwd;
  logic [9:0]  w_pos_nxt;
  logic        w_flip;

  assign w_fwd = {1'b0, r_pos} + STEP;

  // o_flip reports what the next step would do; the top qualifies it with the step enable.
  always_comb begin
    w_pos_nxt = r_pos;
    w_flip    = 1'b0;
    if (r_dir) begin
      if (w_fwd > LIM) begin
        w_pos_nxt = LIM[9:0];
        w_flip    = 1'b1;
      end else begin
        w_pos_nxt = w_fwd[9:0];
      end
    end else begin
      if ({1'b0, r_pos} < STEP) begin
        w_pos_nxt = '0;
        w_flip    = 1'b1;
      end else begin
        w_pos_nxt = r_pos - SPEED;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos <= '0;
      r_dir <= 1'b1;
    end else if (i_step) begin
      r_pos <= w_pos_nxt;
      r_dir <= r_dir ^ w_flip;
    end
  end

  assign o_pos  = r_pos;
  assign o_flip = w_flip;

endmodule

// File: rtl/vga_sprite_gen.sv
// Bouncing square sprite over a grid background; colour returned one clock after request.
module vga_sprite_gen
  import vga_pkg::*;
#(
  parameter logic [9:0] SPRITE_SIZE = 10'd32,
  parameter logic [9:0] SPEED_X     = 10'd2,
  parameter logic [9:0] SPEED_Y     = 10'd1,
  parameter rgb444_t    COLOR_INIT  = 12'hF00,
  parameter rgb444_t    BG_COLOR    = 12'h00F,
  parameter rgb444_t    GRID_COLOR  = 12'h444
) (
  input logic             i_vga_clk,
  input logic             i_rst_n,
  vga_sprite_gen_if.slave io_vga
);

  logic        r_vs_d;
  logic        r_bounce;
  logic [15:0] r_frame_cnt;
  rgb444_t     r_color;
  rgb444_t     r_pixel;

  logic        w_tick;
  logic        w_step;
  logic        w_flip_x;
  logic        w_flip_y;
  logic        w_flip;
  logic [9:0]  w_x;
  logic [9:0]  w_y;
  logic [9:0]  w_row;
  logic        w_in_x;
  logic        w_in_y;
  rgb444_t     w_pixel;

  assign w_tick = r_vs_d & ~io_vga.vga_vs;
  assign w_step = w_tick & ~io_vga.pause;
  assign w_flip = w_flip_x | w_flip_y;

  vga_bounce_axis #(
    .DISP  (H_DISP),
    .SIZE  (SPRITE_SIZE),
    .SPEED (SPEED_X)
  ) u_axis_x (
    .i_clk   (i_vga_clk),
    .i_rst_n (i_rst_n),
    .i_step  (w_step),
    .o_pos   (w_x),
    .o_flip  (w_flip_x)
  );

  vga_bounce_axis #(
    .DISP  (V_DISP),
    .SIZE  (SPRITE_SIZE),
    .SPEED (SPEED_Y)
  ) u_axis_y (
    .i_clk   (i_vga_clk),
    .i_rst_n (i_rst_n),
    .i_step  (w_step),
    .o_pos   (w_y),
    .o_flip  (w_flip_y)
  );

  // ypos is row+1, so ypos==0 marks "no request" and row is only meaningful otherwise.
  assign w_row  = io_vga.pixel_ypos - 10'd1;
  assign w_in_x = ({1'b0, io_vga.pixel_xpos} >= {1'b0, w_x}) &&
                  ({1'b0, io_vga.pixel_xpos} < ({1'b0, w_x} + {1'b0, SPRITE_SIZE}));
  assign w_in_y = ({1'b0, w_row} >= {1'b0, w_y}) &&
                  ({1'b0, w_row} < ({1'b0, w_y} + {1'b0, SPRITE_SIZE}));

  always_comb begin
    w_pixel = BG_COLOR;
    if (io_vga.pixel_ypos == 10'd0) begin
      w_pixel = '0;
    end else if (w_in_x && w_in_y) begin
      w_pixel = r_color;
    end else if ((io_vga.pixel_xpos[4:0] == 5'd0) || (w_row[4:0] == 5'd0)) begin
      w_pixel = GRID_COLOR;
    end
  end

  always_ff @(posedge i_vga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_d      <= 1'b0;
      r_bounce    <= 1'b0;
      r_frame_cnt <= '0;
      r_color     <= COLOR_INIT;
      r_pixel     <= '0;
    end else begin
      r_vs_d   <= io_vga.vga_vs;
      r_bounce <= w_step & w_flip;
      r_pixel  <= w_pixel;
      if (w_tick) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      // A corner hit flips both axes but still rotates only once.
      if (w_step && w_flip) begin
        r_color <= rot_nibble(r_color);
      end
    end
  end

  assign io_vga.pixel_data = r_pixel;
  assign io_vga.bounce     = r_bounce;
  assign io_vga.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Directed bench: default sprite plus a 160-px sprite tuned to reach a corner quickly.
module tb_vga_sprite_gen;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b1;
  logic [9:0] xpos = '0;
  logic [9:0] ypos = '0;
  logic       pause = 1'b0;

  always #5 clk = ~clk;

  vga_sprite_gen_if bus0();
  vga_sprite_gen_if bus1();

  assign bus0.vga_vs     = vs;
  assign bus0.pixel_xpos = xpos;
  assign bus0.pixel_ypos = ypos;
  assign bus0.pause      = pause;
  assign bus1.vga_vs     = vs;
  assign bus1.pixel_xpos = xpos;
  assign bus1.pixel_ypos = ypos;
  assign bus1.pause      = pause;

  vga_sprite_gen u_dut0 (
    .i_vga_clk (clk),
    .i_rst_n   (rst_n),
    .io_vga    (bus0.slave)
  );

  vga_sprite_gen #(
    .SPRITE_SIZE (10'd160),
    .SPEED_X     (10'd3),
    .SPEED_Y     (10'd2)
  ) u_dut1 (
    .i_vga_clk (clk),
    .i_rst_n   (rst_n),
    .io_vga    (bus1.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   nb0 = 0;
  int   nb1 = 0;
  logic lb0, lb1, tb0, tb1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input int xp, input int yp, input int sx,
                                          input int sy, input int sz, input logic [11:0] col);
    int row;
    if (yp == 0) return 12'h000;
    row = yp - 1;
    if (xp >= sx && xp < sx + sz && row >= sy && row < sy + sz) return col;
    if ((xp % 32) == 0 || (row % 32) == 0) return 12'h444;
    return 12'h00F;
  endfunction

  // One vsync falling edge then a rising edge, recording bounce after each cycle.
  task automatic do_tick();
    ypos = '0;
    vs = 1'b0;
    @(posedge clk); #1;
    lb0 = bus0.bounce; lb1 = bus1.bounce;
    vs = 1'b1;
    @(posedge clk); #1;
    tb0 = bus0.bounce; tb1 = bus1.bounce;
    nb0 += int'(lb0) + int'(tb0);
    nb1 += int'(lb1) + int'(tb1);
  endtask

  task automatic req(input int x, input int y, output logic [11:0] d0, output logic [11:0] d1);
    xpos = 10'(x);
    ypos = 10'(y);
    @(posedge clk); #1;
    d0 = bus0.pixel_data;
    d1 = bus1.pixel_data;
  endtask

  // Two pixels just inside opposite corners and two just outside pin the sprite exactly.
  task automatic probe(input int inst, input string tag, input int sx, input int sy,
                       input logic [11:0] col);
    int sz;
    int px[4];
    int pr[4];
    logic [11:0] d0, d1, got;
    sz = (inst == 1) ? 160 : 32;
    px[0] = sx;          pr[0] = sy;
    px[1] = sx + sz - 1; pr[1] = sy + sz - 1;
    px[2] = sx + sz;     pr[2] = sy;
    px[3] = sx;          pr[3] = sy + sz;
    for (int i = 0; i < 4; i++) begin
      req(px[i], pr[i] + 1, d0, d1);
      got = (inst == 1) ? d1 : d0;
      check($sformatf("%s_p%0d", tag, i), 32'(got),
            32'(exp_pix(px[i], pr[i] + 1, sx, sy, sz, col)));
    end
  endtask

  logic [11:0] d0, d1;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_pix", 32'(bus0.pixel_data), 32'h000);
    check("rst_frame", 32'(bus0.frame_cnt), 32'd0);
    check("rst_bounce", 32'(bus0.bounce), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("rst_no_tick", 32'(bus0.frame_cnt), 32'd0);
    req(0, 1, d0, d1);
    check("rst_req01", 32'(d0), 32'hF00);

    req(5, 6, d0, d1);
    check("org_5_6", 32'(d0), 32'hF00);
    req(40, 6, d0, d1);
    check("org_40_6", 32'(d0), 32'h00F);
    xpos = 10'd32; ypos = 10'd10;
    #3 check("lat_hold", 32'(bus0.pixel_data), 32'h00F);
    @(posedge clk); #1;
    check("org_32_10", 32'(bus0.pixel_data), 32'h444);
    req(5, 0, d0, d1);
    check("org_y0", 32'(d0), 32'h000);
    probe(0, "org0", 0, 0, 12'hF00);
    probe(1, "org1", 0, 0, 12'hF00);

    repeat (10) do_tick();
    check("mot_frame", 32'(bus0.frame_cnt), 32'd10);
    probe(0, "mot0", 20, 10, 12'hF00);
    probe(1, "mot1", 30, 20, 12'hF00);

    repeat (150) do_tick();
    check("c_pre_nb1", 32'(nb1), 32'd0);
    probe(1, "c_pre", 480, 320, 12'hF00);
    do_tick();
    check("c_pulse", 32'(lb1), 32'd1);
    check("c_pulse_end", 32'(tb1), 32'd0);
    check("c_nb1", 32'(nb1), 32'd1);
    probe(1, "c_hit", 480, 320, 12'h00F);
    do_tick();
    probe(1, "c_back", 477, 318, 12'h00F);

    repeat (141) do_tick();
    probe(0, "r_606", 606, 303, 12'hF00);
    do_tick();
    check("r_lim_nb0", 32'(nb0), 32'd0);
    probe(0, "r_lim", 608, 304, 12'hF00);
    do_tick();
    check("r_pulse", 32'(lb0), 32'd1);
    check("r_pulse_end", 32'(tb0), 32'd0);
    check("r_nb0", 32'(nb0), 32'd1);
    probe(0, "r_flip", 608, 305, 12'h00F);
    do_tick();
    probe(0, "r_back", 606, 306, 12'h00F);
    probe(1, "r_i1", 45, 30, 12'h00F);
    check("r_frame", 32'(bus0.frame_cnt), 32'd306);

    pause = 1'b1;
    repeat (5) do_tick();
    check("p_frame", 32'(bus0.frame_cnt), 32'd311);
    check("p_nb0", 32'(nb0), 32'd1);
    probe(0, "p_hold", 606, 306, 12'h00F);
    pause = 1'b0;
    do_tick();
    probe(0, "p_release", 604, 307, 12'h00F);
    pause = 1'b1;
    do_tick();
    probe(0, "p_edge", 604, 307, 12'h00F);
    check("p_frame2", 32'(bus0.frame_cnt), 32'd313);
    pause = 1'b0;

    req(604, 308, d0, d1);
    check("mid_pix", 32'(d0), 32'h00F);
    vs = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid_rst_pix", 32'(bus0.pixel_data), 32'h000);
    check("mid_rst_frame", 32'(bus0.frame_cnt), 32'd0);
    check("mid_rst_bounce", 32'(bus0.bounce), 32'd0);
    @(posedge clk); #1;
    vs = 1'b1;
    rst_n = 1'b1;
    probe(0, "post_rst", 0, 0, 12'hF00);
    check("post_rst_frame", 32'(bus0.frame_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
